// File: rtl/wave_capture_buf.sv
// Trigger-aligned capture buffer: circular sample RAM, edge trigger, frozen frame read port.
// Define AUTO_TRIG_EN to build the free-run forced trigger after AUTO_TIMEOUT armed samples.
module wave_capture_buf #(
    parameter int unsigned DEPTH        = 480,
    parameter int unsigned PRE_TRIG     = 240,
    parameter logic [23:0] AUTO_TIMEOUT = 24'd2_500_000
) (
    input  logic       clk_25m,
    input  logic       rst_n,
    input  logic [7:0] ad_data,
    input  logic       ad_valid,
    input  logic [7:0] trig_level,
    input  logic       trig_edge,
    input  logic [8:0] wave_addr,
    input  logic       wave_data_req,
    input  logic       wr_over,
    output logic [7:0] wave_data,
    output logic       frame_ready,
    output logic       trig_found,
    output logic [1:0] cap_state
);

    localparam logic [9:0] DepthW   = 10'(DEPTH);
    localparam logic [9:0] PreW     = 10'(PRE_TRIG);
    localparam logic [8:0] PreLast  = 9'(PRE_TRIG - 1);
    localparam logic [8:0] PostLen  = 9'(DEPTH - PRE_TRIG);
    localparam logic [8:0] LastAddr = 9'(DEPTH - 1);

    typedef enum logic [1:0] {
        StPre  = 2'b00,
        StArm  = 2'b01,
        StPost = 2'b10,
        StHold = 2'b11
    } cap_state_e;

    cap_state_e state_q, state_d;
    logic [8:0] wp_q, wp_d;
    logic [8:0] cnt_q, cnt_d;
    logic [8:0] tp_q, tp_d;
    logic [7:0] prev_q, prev_d;
    logic       prev_valid_q, prev_valid_d;
    logic       trig_found_q, trig_found_d;
    logic       frame_ready_q, frame_ready_d;
    logic       rd_ok_q, rd_ok_d;
    logic [7:0] rd_data_q;
    logic       we;
    logic       hit;
    logic       force_trig;

`ifdef AUTO_TRIG_EN
    logic [23:0] auto_cnt_q, auto_cnt_d;
`else
    logic unused_auto_timeout;
    assign unused_auto_timeout = ^AUTO_TIMEOUT;
`endif

    logic [7:0] mem_q [DEPTH];

    // Crossing test against the previous sample; prev_valid blocks a stale compare after re-arm.
    always_comb begin
        hit = 1'b0;
        if (prev_valid_q) begin
            if (trig_edge) begin
                hit = (prev_q > trig_level) && (ad_data <= trig_level);
            end else begin
                hit = (prev_q < trig_level) && (ad_data >= trig_level);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wp_d          = wp_q;
        cnt_d         = cnt_q;
        tp_d          = tp_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        trig_found_d  = trig_found_q;
        frame_ready_d = frame_ready_q;
        we            = 1'b0;
        force_trig    = 1'b0;
`ifdef AUTO_TRIG_EN
        auto_cnt_d    = auto_cnt_q;
`endif

        unique case (state_q)
            StPre: begin
                if (ad_valid) begin
                    we = 1'b1;
                    if (cnt_q == PreLast) begin
                        state_d = StArm;
                        cnt_d   = '0;
`ifdef AUTO_TRIG_EN
                        auto_cnt_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            StArm: begin
                if (ad_valid) begin
                    we = 1'b1;
`ifdef AUTO_TRIG_EN
                    if (auto_cnt_q == AUTO_TIMEOUT) begin
                        force_trig = 1'b1;
                    end else begin
                        auto_cnt_d = auto_cnt_q + 24'd1;
                    end
`endif
                    if (hit || force_trig) begin
                        tp_d         = wp_q;
                        trig_found_d = hit;
                        state_d      = StPost;
                        // The trigger sample itself is the first post-trigger write.
                        cnt_d        = 9'd1;
                    end
                end
            end
            StPost: begin
                if (cnt_q == PostLen) begin
                    state_d       = StHold;
                    frame_ready_d = 1'b1;
                end else if (ad_valid) begin
                    we    = 1'b1;
                    cnt_d = cnt_q + 9'd1;
                end
            end
            StHold: begin
                if (wr_over) begin
                    state_d       = StPre;
                    cnt_d         = '0;
                    prev_valid_d  = 1'b0;
                    trig_found_d  = 1'b0;
                    frame_ready_d = 1'b0;
                end
            end
            default: state_d = StPre;
        endcase

        if (we) begin
            wp_d         = (wp_q == LastAddr) ? 9'd0 : wp_q + 9'd1;
            prev_d       = ad_data;
            prev_valid_d = 1'b1;
        end
    end

    // Frame column -> RAM address: (tp - PRE_TRIG + col) mod DEPTH without a divider.
    logic [8:0] col;
    logic [9:0] sum_addr;
    logic [9:0] off_addr;
    logic [9:0] rd_addr_w;
    logic [8:0] rd_addr;
    logic       unused_rd_msb;

    always_comb begin
        col       = (10'(wave_addr) >= DepthW) ? LastAddr : wave_addr;
        sum_addr  = 10'(tp_q) + 10'(col);
        off_addr  = (sum_addr >= PreW) ? sum_addr - PreW : sum_addr + DepthW - PreW;
        rd_addr_w = (off_addr >= DepthW) ? off_addr - DepthW : off_addr;
        rd_addr   = rd_addr_w[8:0];
    end

    assign unused_rd_msb = rd_addr_w[9];

    always_comb begin
        rd_ok_d = rd_ok_q;
        if (wave_data_req) begin
            rd_ok_d = (state_q == StHold);
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StPre;
            wp_q          <= '0;
            cnt_q         <= '0;
            tp_q          <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            trig_found_q  <= 1'b0;
            frame_ready_q <= 1'b0;
            rd_ok_q       <= 1'b0;
`ifdef AUTO_TRIG_EN
            auto_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wp_q          <= wp_d;
            cnt_q         <= cnt_d;
            tp_q          <= tp_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            trig_found_q  <= trig_found_d;
            frame_ready_q <= frame_ready_d;
            rd_ok_q       <= rd_ok_d;
`ifdef AUTO_TRIG_EN
            auto_cnt_q    <= auto_cnt_d;
`endif
        end
    end

    // Plain RAM with registered read so it maps onto block memory.
    always_ff @(posedge clk_25m) begin
        if (we) begin
            mem_q[wp_q] <= ad_data;
        end
        if (wave_data_req) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign wave_data   = rd_ok_q ? rd_data_q : 8'd0;
    assign frame_ready = frame_ready_q;
    assign trig_found  = trig_found_q;
    assign cap_state   = state_q;

endmodule

// File: tb/tb_wave_capture_buf.sv
// Self-checking bench for wave_capture_buf: history-queue reference model checked every cycle,
// directed trigger/alignment cases plus a randomized run. Honours AUTO_TRIG_EN like the RTL.
module tb_wave_capture_buf;

    localparam int DEPTH    = 480;
    localparam int PRE_TRIG = 240;
    localparam int POST_LEN = DEPTH - PRE_TRIG;
    localparam int TIMEOUT  = 16;
`ifdef AUTO_TRIG_EN
    localparam bit AUTO_ON = 1'b1;
`else
    localparam bit AUTO_ON = 1'b0;
`endif

    logic       clk_25m = 1'b0;
    logic       rst_n;
    logic [7:0] ad_data;
    logic       ad_valid;
    logic [7:0] trig_level;
    logic       trig_edge;
    logic [8:0] wave_addr;
    logic       wave_data_req;
    logic       wr_over;
    logic [7:0] wave_data;
    logic       frame_ready;
    logic       trig_found;
    logic [1:0] cap_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_25m = ~clk_25m;

    wave_capture_buf #(
        .DEPTH(DEPTH),
        .PRE_TRIG(PRE_TRIG),
        .AUTO_TIMEOUT(24'(TIMEOUT))
    ) dut (
        .clk_25m(clk_25m),
        .rst_n(rst_n),
        .ad_data(ad_data),
        .ad_valid(ad_valid),
        .trig_level(trig_level),
        .trig_edge(trig_edge),
        .wave_addr(wave_addr),
        .wave_data_req(wave_data_req),
        .wr_over(wr_over),
        .wave_data(wave_data),
        .frame_ready(frame_ready),
        .trig_found(trig_found),
        .cap_state(cap_state)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: phase 0..3, every sample written since the last re-arm kept in order.
    int          m_ph = 0;
    byte unsigned hist[$];
    int          trig_idx = 0;
    int          arm_n = 0;
    bit          m_found = 1'b0;
    logic [7:0]  m_data = 8'd0;
    logic [7:0]  m_prev;
    bit          m_hit;
    bit          m_forced;

    function automatic logic [7:0] frame_at(input int c);
        int colm;
        colm = (c >= DEPTH) ? DEPTH - 1 : c;
        return hist[trig_idx - PRE_TRIG + colm];
    endfunction

    always @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 0;
            hist.delete();
            trig_idx = 0;
            arm_n = 0;
            m_found = 1'b0;
            m_data = 8'd0;
        end else begin
            if (wave_data_req) m_data = (m_ph == 3) ? frame_at(int'(wave_addr)) : 8'd0;
            case (m_ph)
                0: if (ad_valid) begin
                    hist.push_back(ad_data);
                    if (hist.size() == PRE_TRIG) begin
                        m_ph = 1;
                        arm_n = 0;
                    end
                end
                1: if (ad_valid) begin
                    m_prev = hist[$];
                    m_hit = trig_edge ? (m_prev > trig_level && ad_data <= trig_level)
                                      : (m_prev < trig_level && ad_data >= trig_level);
                    m_forced = AUTO_ON && (arm_n == TIMEOUT);
                    hist.push_back(ad_data);
                    arm_n++;
                    if (m_hit || m_forced) begin
                        trig_idx = hist.size() - 1;
                        m_found = m_hit;
                        m_ph = 2;
                    end
                end
                2: begin
                    if (hist.size() - trig_idx >= POST_LEN) m_ph = 3;
                    else if (ad_valid) hist.push_back(ad_data);
                end
                default: if (wr_over) begin
                    m_ph = 0;
                    hist.delete();
                    m_found = 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk_25m) begin
        check("cap_state", int'(cap_state), m_ph);
        check("frame_ready", int'(frame_ready), int'(m_ph == 3));
        check("trig_found", int'(trig_found), int'(m_found));
        check("wave_data", int'(wave_data), int'(m_data));
    end

    task automatic tick();
        @(posedge clk_25m);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        ad_valid = 1'b1;
        ad_data  = d;
        tick();
        ad_valid = 1'b0;
    endtask

    function automatic logic [7:0] gen(input int kind, input int i);
        int p;
        case (kind)
            0: return 8'(i % 256);
            1: begin
                p = i % 400;
                return 8'((p <= 200) ? 200 - p : p - 200);
            end
            default: return 8'd10;
        endcase
    endfunction

    task automatic capture(input int kind, input int limit, output int n);
        n = 0;
        while (!frame_ready && n < limit) begin
            feed(gen(kind, n));
            n++;
        end
        check("capture_reached_hold", int'(frame_ready), 1);
    endtask

    task automatic read_col(input int c, output logic [7:0] v);
        wave_data_req = 1'b1;
        wave_addr     = 9'(c);
        tick();
        wave_data_req = 1'b0;
        v = wave_data;
    endtask

    task automatic read_all_busy();
        for (int c = 0; c < DEPTH; c++) begin
            wave_data_req = 1'b1;
            wave_addr     = 9'(c);
            ad_valid      = 1'b1;
            ad_data       = 8'($urandom);
            tick();
        end
        wave_data_req = 1'b0;
        ad_valid      = 1'b0;
    endtask

    task automatic rearm();
        wr_over = 1'b1;
        tick();
        wr_over = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] v;
        int n;
        int posts;

        rst_n = 1'b0; ad_data = '0; ad_valid = 1'b0; trig_level = '0; trig_edge = 1'b0;
        wave_addr = '0; wave_data_req = 1'b0; wr_over = 1'b0;
        repeat (3) @(posedge clk_25m);
        #1;
        check("reset_cap_state", int'(cap_state), 0);
        check("reset_frame_ready", int'(frame_ready), 0);
        check("reset_trig_found", int'(trig_found), 0);
        check("reset_wave_data", int'(wave_data), 0);
        rst_n = 1'b1;
        tick();

        // Rising ramp, level 100: trigger sample 100 lands on column 240.
        trig_level = 8'd100;
        trig_edge  = 1'b0;
        capture(0, 2000, n);
`ifndef AUTO_TRIG_EN
        read_col(240, v); check("ramp_col240", int'(v), 100);
        read_col(0, v);   check("ramp_col0", int'(v), 116);
        read_col(479, v); check("ramp_col479", int'(v), 83);
        read_col(511, v); check("ramp_col_clamped", int'(v), 83);
        check("ramp_trig_found", int'(trig_found), 1);
`endif
        read_all_busy();
        read_all_busy();
        // Read and release in the same cycle: old frame still served.
        wave_data_req = 1'b1;
        wave_addr     = 9'd240;
        wr_over       = 1'b1;
        tick();
        wave_data_req = 1'b0;
        wr_over       = 1'b0;
`ifndef AUTO_TRIG_EN
        check("read_with_wr_over", int'(wave_data), 100);
`endif
        check("rearm_cap_state", int'(cap_state), 0);
        check("rearm_frame_ready", int'(frame_ready), 0);
        read_col(240, v); check("read_outside_hold", int'(v), 0);

        // Falling triangle, level 50.
        trig_level = 8'd50;
        trig_edge  = 1'b1;
        capture(1, 2000, n);
`ifndef AUTO_TRIG_EN
        read_col(240, v); check("tri_col240", int'(v), 50);
        read_col(239, v); check("tri_col239", int'(v), 51);
        check("tri_trig_found", int'(trig_found), 1);
`endif
        rearm();

        // Constant input never crosses the level.
        trig_level = 8'd100;
        trig_edge  = 1'b0;
`ifdef AUTO_TRIG_EN
        capture(2, 2000, n);
        check("auto_feeds_to_hold", n, 497);
        check("auto_trig_found", int'(trig_found), 0);
        for (int c = 0; c < DEPTH; c++) begin
            read_col(c, v);
            check("auto_col", int'(v), 10);
        end
        rearm();
`else
        repeat (1000) feed(8'd10);
        check("no_auto_stays_arm", int'(cap_state), 1);
        check("no_auto_not_ready", int'(frame_ready), 0);
`endif

        // Reset in the middle of POST after 100 post samples.
        pulse_reset();
        trig_level = 8'd100;
        posts = 0;
        n = 0;
        while (posts < 100 && n < 2000) begin
            feed(gen(0, n));
            n++;
            if (cap_state == 2'b10) posts++;
        end
        check("post_count_reached", posts, 100);
        rst_n = 1'b0;
        #1;
        check("midpost_reset_cap_state", int'(cap_state), 0);
        check("midpost_reset_frame_ready", int'(frame_ready), 0);
        check("midpost_reset_trig_found", int'(trig_found), 0);
        check("midpost_reset_wave_data", int'(wave_data), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fresh write pointer: level 214 is crossed by the sample written at address 470.
        trig_level = 8'd214;
        capture(0, 2000, n);
`ifndef AUTO_TRIG_EN
        for (int c = 0; c < DEPTH; c++) begin
            read_col(c, v);
            check("wrap_contiguous", int'(v), (230 + c) % 256);
        end
        read_col(511, v); check("wrap_col_clamped", int'(v), 197);
`endif
        rearm();

        for (int k = 0; k < 20000; k++) begin
            ad_valid = ($urandom_range(0, 3) != 0);
            ad_data  = 8'($urandom);
            if ($urandom_range(0, 99) == 0) trig_level = 8'($urandom);
            if ($urandom_range(0, 199) == 0) trig_edge = ~trig_edge;
            wave_data_req = 1'($urandom_range(0, 1));
            wave_addr     = 9'($urandom_range(0, 511));
            wr_over       = ($urandom_range(0, 31) == 0);
            rst_n         = ($urandom_range(0, 4999) != 0);
            tick();
        end
        rst_n = 1'b1; ad_valid = 1'b0; wave_data_req = 1'b0; wr_over = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
